updown_mod_counter: RTL and testbench

Parametrised binary counter, next generation of the team's plain 4-bit down counter. Adds up/down direction, programmable modulus, wrap or saturate mode, parallel load, count enable and an integrated prescaler. It generates its own slow count rate from the system clock. Used as a general event/timing counter in display, timer and sequencing blocks.

---
 rtl/updown_mod_counter.sv | 65 ++++++
 tb/tb_updown_mod_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with wrap/saturate, parallel load and prescaler.
// Reset is asynchronous and active-low on rst.
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MOD_VAL  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             zero
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VAL - 1);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    generate
        if (WIDTH < 1 || MOD_VAL < 2 || ((MOD_VAL - 1) >> WIDTH) != 0 || PRESCALE < 1) begin : g_bad
            $error("updown_mod_counter: illegal parameters");
        end
    endgenerate

    logic [PW-1:0]    pcnt;
    logic             step;
    logic             at_lim;
    logic [WIDTH-1:0] q_nxt;

    // the limit depends on direction, so wrap/saturate never exceeds MAX or underflows
    always_comb begin
        step   = en && pcnt == PLAST;
        at_lim = up_dn ? q == MAX : q == '0;
        q_nxt  = at_lim ? (sat ? q : (up_dn ? '0 : MAX)) : (up_dn ? q + 1'b1 : q - 1'b1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            pcnt <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (load) begin
            q    <= (load_val > MAX) ? MAX : load_val;
            pcnt <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (en) begin
            pcnt <= step ? '0 : pcnt + 1'b1;
            tick <= step;
            tc   <= step && at_lim;
            if (step) q <= q_nxt;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

    assign zero = q == '0;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: scoreboard bench for two counter configurations.
module tb_updown_mod_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up_dn = 1'b0, sat = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q0, q1;
    logic       tick0, tc0, zero0, tick1, tc1, zero1;

    always #5 clk = ~clk;

    updown_mod_counter d0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val), .q(q0), .tick(tick0), .tc(tc0), .zero(zero0)
    );

    updown_mod_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(4)) d1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val), .q(q1), .tick(tick1), .tc(tc1), .zero(zero1)
    );

    typedef struct {
        int q0, q1;
        bit t0, c0, t1, c1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   mods[2] = '{16, 10};
    int   pres[2] = '{1, 4};
    int   mq[2]   = '{0, 0};
    int   mp[2]   = '{0, 0};
    bit   mtick[2] = '{0, 0};
    bit   mtc[2]   = '{0, 0};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void mreset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mp[i] = 0; mtick[i] = 0; mtc[i] = 0;
        end
    endfunction

    // reference: a step moves one position; leaving the range either wraps modulo m or clamps
    function automatic void model(int i, bit e, bit ud, bit s, bit ld, int lv);
        int m = mods[i];
        int nxt;
        mtick[i] = 0;
        mtc[i]   = 0;
        if (ld) begin
            mq[i] = (lv < m) ? lv : m - 1;
            mp[i] = 0;
        end else if (e) begin
            mp[i] = (mp[i] + 1) % pres[i];
            if (mp[i] == 0) begin
                nxt      = mq[i] + (ud ? 1 : -1);
                mtick[i] = 1;
                mtc[i]   = (nxt < 0 || nxt >= m);
                mq[i]    = s ? ((nxt < 0) ? 0 : (nxt >= m) ? m - 1 : nxt) : (nxt + m) % m;
            end
        end
    endfunction

    task automatic cyc(input bit e, input bit ud, input bit s, input bit ld, input int lv);
        exp_t x;
        @(negedge clk);
        en = e; up_dn = ud; sat = s; load = ld; load_val = 4'(lv);
        for (int i = 0; i < 2; i++) model(i, e, ud, s, ld, lv);
        x.q0 = mq[0]; x.t0 = mtick[0]; x.c0 = mtc[0];
        x.q1 = mq[1]; x.t1 = mtick[1]; x.c1 = mtc[1];
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q0", q0, x.q0);
                chk("tick0", tick0, x.t0);
                chk("tc0", tc0, x.c0);
                chk("zero0", zero0, x.q0 == 0);
                chk("q1", q1, x.q1);
                chk("tick1", tick1, x.t1);
                chk("tc1", tc1, x.c1);
                chk("zero1", zero1, x.q1 == 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        #2;
        chk("rst_q0", q0, 0);
        chk("rst_q1", q1, 0);
        chk("rst_tc0", tc0, 0);
        chk("rst_tick1", tick1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // legacy wrapping down count
        repeat (18) cyc(1, 0, 0, 0, 0);
        // up with wrap
        repeat (12) cyc(1, 1, 0, 0, 0);
        // load then saturating down, then back up
        cyc(0, 0, 0, 1, 2);
        repeat (5) cyc(1, 0, 1, 0, 0);
        repeat (3) cyc(1, 1, 1, 0, 0);
        // prescale pause keeps the partial count
        cyc(0, 1, 0, 1, 0);
        repeat (2) cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        repeat (6) cyc(1, 1, 0, 0, 0);
        // out-of-range load with en high clamps and clears prescaler
        cyc(1, 1, 0, 1, 12);
        repeat (6) cyc(1, 1, 1, 0, 0);
        // randomized traffic
        repeat (400)
            cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));
        // run to a terminal count, then reset between edges
        n = 0;
        do begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end while (!mtc[0] && n < 40);
        chk("tc_seen", mtc[0], 1);
        @(posedge clk);
        #3;
        chk("pre_rst_tc0", tc0, 1);
        rst = 1'b0;
        en = 1'b0; load = 1'b0;
        #1;
        chk("async_q0", q0, 0);
        chk("async_tc0", tc0, 0);
        chk("async_tick0", tick0, 0);
        chk("async_q1", q1, 0);
        mreset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) cyc(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
